outport_sched: RTL and testbench

//  Packet-level scheduler for one router output port. Arbitrates among the NPORT

---
 rtl/outport_sched_if.sv | 44 ++++
 rtl/outport_sched.sv | 192 +++++++++++++++++++
 tb/tb_outport_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/outport_sched_if.sv
// -----------------------------------------------------------------------------
// outport_sched_if
//  Bundles the request side and the status/grant side of one output-port
//  scheduler.
//
//  Ports carried (widths from NPORT / CW):
//   req        [NPORT]  input i has a flit for this output port
//   mcast      [NPORT]  request i belongs to a multicast packet
//   tail       [NPORT]  flit presented by input i is a tail flit
//   credit_in  [1]      downstream freed one buffer slot
//   grt        [NPORT]  one-hot registered grant / crossbar select
//   xfer       [1]      a flit moves this cycle
//   busy       [1]      a packet currently owns the port
//   credit_cnt [CW]     available downstream credits
//   credit_err [1]      sticky credit overflow flag
//
//  Modports:
//   master - request/credit source (drives req/mcast/tail/credit_in)
//   slave  - the scheduler (drives grant and status)
// -----------------------------------------------------------------------------
interface outport_sched_if #(
  parameter int NPORT = 5,
  parameter int CW    = 3
);
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] mcast;
  logic [NPORT-1:0] tail;
  logic             credit_in;
  logic [NPORT-1:0] grt;
  logic             xfer;
  logic             busy;
  logic [CW-1:0]    credit_cnt;
  logic             credit_err;

  modport master (
    output req, mcast, tail, credit_in,
    input  grt, xfer, busy, credit_cnt, credit_err
  );

  modport slave (
    input  req, mcast, tail, credit_in,
    output grt, xfer, busy, credit_cnt, credit_err
  );
endinterface

// File: rtl/outport_sched.sv
// -----------------------------------------------------------------------------
// outport_sched
//  Packet-level scheduler for one router output port. Arbitrates among NPORT
//  inputs routed to this port, holds the grant from head to tail so wormhole
//  packets never interleave, and gates every flit on downstream credits.
//
//  Ports:
//   clk   in  clock
//   rst_  in  asynchronous active-low reset
//   bus   outport_sched_if.slave (req/mcast/tail/credit_in in;
//         grt/xfer/busy/credit_cnt/credit_err out)
//
//  Optional feature macro: OSCHED_AGING_EN
//   When defined, each input carries a saturating age counter; inputs that
//   reach AGE_MAX win arbitration ahead of the multicast/unicast classes,
//   which prevents multicast traffic from starving unicast requesters.
// -----------------------------------------------------------------------------
module outport_sched #(
  parameter int NPORT   = 5,
  parameter int CREDITS = 4,
`ifdef OSCHED_AGING_EN
  parameter int AGE_MAX = 15,
`endif
  parameter int CW      = 3
) (
  input  logic           clk,
  input  logic           rst_,
  outport_sched_if.slave bus
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [NPORT-1:0] grt_reg, grt_next;
  logic [PW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]    credit_cnt_reg;
  logic             credit_err_reg;

  logic [NPORT-1:0] cand;
  logic [PW-1:0]    win_idx;
  logic             win_found;
  logic [PW-1:0]    owner_idx;
  logic             owner_tail;
  logic             xfer;

  // A flit moves only when the owner presents one and a credit is available,
  // so the counter can never underflow.
  assign xfer       = (|(grt_reg & bus.req)) && (credit_cnt_reg != '0);
  assign owner_tail = |(grt_reg & bus.tail);

  assign bus.grt        = grt_reg;
  assign bus.xfer       = xfer;
  assign bus.busy       = (state_reg == BUSY);
  assign bus.credit_cnt = credit_cnt_reg;
  assign bus.credit_err = credit_err_reg;

  // ---------------------------------------------------------------------------
  // Optional starvation aging
  // ---------------------------------------------------------------------------
`ifdef OSCHED_AGING_EN
  localparam int AW = $clog2(AGE_MAX + 1);

  logic [AW-1:0]    age_reg [NPORT];
  logic [NPORT-1:0] aged;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_age
    // Age only while waiting: the owner and idle inputs are held at zero.
    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        age_reg[gi] <= '0;
      end else if (!bus.req[gi] || grt_reg[gi]) begin
        age_reg[gi] <= '0;
      end else if (age_reg[gi] != AW'(AGE_MAX)) begin
        age_reg[gi] <= age_reg[gi] + 1'b1;
      end
    end

    assign aged[gi] = bus.req[gi] && (age_reg[gi] == AW'(AGE_MAX));
  end

  // Priority classes: aged > multicast > unicast.
  always_comb begin
    cand = bus.req & ~bus.mcast;
    if (|aged)
      cand = aged;
    else if (|(bus.req & bus.mcast))
      cand = bus.req & bus.mcast;
  end
`else
  // Priority classes: multicast > unicast.
  always_comb begin
    cand = bus.req & ~bus.mcast;
    if (|(bus.req & bus.mcast))
      cand = bus.req & bus.mcast;
  end
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: first candidate at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NPORT;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Current owner index recovered from the one-hot grant.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (grt_reg[i])
        owner_idx = PW'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg  <= IDLE;
      grt_reg    <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grt_reg    <= grt_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grt_next    = grt_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        // Arbitration ignores credits; the grant is taken and the flit waits.
        if (win_found) begin
          grt_next          = '0;
          grt_next[win_idx] = 1'b1;
          state_next        = BUSY;
        end
      end
      BUSY: begin
        // Release only on the tail flit actually moving; the round-robin
        // pointer advances only on packet completion.
        if (xfer && owner_tail) begin
          grt_next    = '0;
          state_next  = IDLE;
          rr_ptr_next = (owner_idx == PW'(NPORT - 1)) ? '0 : owner_idx + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Downstream credits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      credit_cnt_reg <= CW'(CREDITS);
      credit_err_reg <= 1'b0;
    end else begin
      case ({xfer, bus.credit_in})
        2'b10: credit_cnt_reg <= credit_cnt_reg - 1'b1;
        2'b01: begin
          // A return with nothing outstanding is a protocol error upstream;
          // clamp and flag it until reset.
          if (credit_cnt_reg == CW'(CREDITS))
            credit_err_reg <= 1'b1;
          else
            credit_cnt_reg <= credit_cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_outport_sched.sv
module tb_outport_sched;

  logic clk;
  logic rst_;
  int   vectors;
  int   miscompares;

  outport_sched_if #(.NPORT(5), .CW(3)) bus_if ();

  outport_sched #(
    .NPORT  (5),
    .CREDITS(4),
    .CW     (3)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_             = 1'b0;
    bus_if.req       = '0;
    bus_if.mcast     = '0;
    bus_if.tail      = '0;
    bus_if.credit_in = 1'b0;
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  // Starting in IDLE with req already set: grant edge, nflits transfers
  // (tail on the last), then one check in the following IDLE cycle.
  // credit_in is pulsed alongside each flit so the counter stays full.
  task automatic run_pkt(input logic [4:0] exp_grt, input int nflits, input string tag);
    bus_if.credit_in = 1'b0;
    bus_if.tail      = '0;
    tick();
    for (int f = 1; f <= nflits; f++) begin
      bus_if.credit_in = 1'b1;
      bus_if.tail      = (f == nflits) ? 5'b11111 : 5'b00000;
      @(negedge clk);
      chk({tag, "_grt"}, 32'(bus_if.grt), 32'(exp_grt));
      chk({tag, "_xfer"}, 32'(bus_if.xfer), 32'd1);
      tick();
    end
    bus_if.credit_in = 1'b0;
    bus_if.tail      = '0;
    @(negedge clk);
    chk({tag, "_rel_grt"}, 32'(bus_if.grt), 32'd0);
    chk({tag, "_rel_busy"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // ---- 1: reset state, single-flit packet from input 2
    do_reset();
    chk("rst_grt", 32'(bus_if.grt), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_xfer", 32'(bus_if.xfer), 32'd0);
    chk("rst_cnt", 32'(bus_if.credit_cnt), 32'd4);
    chk("rst_err", 32'(bus_if.credit_err), 32'd0);
    bus_if.req = 5'b00100;
    run_pkt(5'b00100, 1, "t1");
    chk("t1_rr", 32'(dut.rr_ptr_reg), 32'd3);
    chk("t1_cnt", 32'(bus_if.credit_cnt), 32'd4);
    $display("t1 single flit input2 done");

    // ---- 2: two unicast requesters, 3-flit packets alternate
    do_reset();
    bus_if.req = 5'b10001;
    run_pkt(5'b00001, 3, "t2a");
    run_pkt(5'b10000, 3, "t2b");
    run_pkt(5'b00001, 3, "t2c");
    $display("t2 round robin 3x3 flits done");

    // ---- 3: multicast class wins even though rr_ptr favours input 0
    do_reset();
    bus_if.req   = 5'b00011;
    bus_if.mcast = 5'b00010;
    run_pkt(5'b00010, 1, "t3");
    chk("t3_rr", 32'(dut.rr_ptr_reg), 32'd2);
    $display("t3 multicast priority done");

    // ---- 4: 6-flit packet with 4 credits, stall, then two credit returns
    do_reset();
    bus_if.req = 5'b00001;
    tick();
    for (int f = 1; f <= 4; f++) begin
      @(negedge clk);
      chk("t4_grt", 32'(bus_if.grt), 32'd1);
      chk("t4_xfer", 32'(bus_if.xfer), 32'd1);
      chk("t4_cnt", 32'(bus_if.credit_cnt), 32'(5 - f));
      tick();
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("t4_stall_xfer", 32'(bus_if.xfer), 32'd0);
      chk("t4_stall_grt", 32'(bus_if.grt), 32'd1);
      chk("t4_stall_cnt", 32'(bus_if.credit_cnt), 32'd0);
      tick();
    end
    bus_if.credit_in = 1'b1;
    @(negedge clk);
    chk("t4_c1_xfer", 32'(bus_if.xfer), 32'd0);
    tick();
    bus_if.credit_in = 1'b0;
    @(negedge clk);
    chk("t4_f5_xfer", 32'(bus_if.xfer), 32'd1);
    chk("t4_f5_cnt", 32'(bus_if.credit_cnt), 32'd1);
    tick();
    bus_if.credit_in = 1'b1;
    @(negedge clk);
    chk("t4_c2_xfer", 32'(bus_if.xfer), 32'd0);
    tick();
    bus_if.credit_in = 1'b0;
    bus_if.tail      = 5'b00001;
    @(negedge clk);
    chk("t4_f6_xfer", 32'(bus_if.xfer), 32'd1);
    tick();
    bus_if.req  = '0;
    bus_if.tail = '0;
    @(negedge clk);
    chk("t4_end_cnt", 32'(bus_if.credit_cnt), 32'd0);
    chk("t4_end_grt", 32'(bus_if.grt), 32'd0);
    $display("t4 credit stall and resume done");

    // ---- 5: simultaneous credit_in + xfer, then overflow error
    do_reset();
    bus_if.req = 5'b00001;
    tick();
    tick();
    tick();
    bus_if.credit_in = 1'b1;
    @(negedge clk);
    chk("t5_both_cnt_pre", 32'(bus_if.credit_cnt), 32'd2);
    chk("t5_both_xfer", 32'(bus_if.xfer), 32'd1);
    tick();
    bus_if.credit_in = 1'b0;
    bus_if.tail      = 5'b00001;
    @(negedge clk);
    chk("t5_both_cnt_post", 32'(bus_if.credit_cnt), 32'd2);
    tick();
    bus_if.req       = '0;
    bus_if.tail      = '0;
    bus_if.credit_in = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t5_full_cnt", 32'(bus_if.credit_cnt), 32'd4);
    chk("t5_err_pre", 32'(bus_if.credit_err), 32'd0);
    tick();
    bus_if.credit_in = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(bus_if.credit_err), 32'd1);
    chk("t5_ovf_cnt", 32'(bus_if.credit_cnt), 32'd4);
    tick();
    tick();
    @(negedge clk);
    chk("t5_err_sticky", 32'(bus_if.credit_err), 32'd1);
    $display("t5 credit same-cycle and overflow done");

    // ---- 6: asynchronous reset mid-packet
    do_reset();
    bus_if.req = 5'b00001;
    tick();
    tick();
    @(negedge clk);
    chk("t6_pre_cnt", 32'(bus_if.credit_cnt), 32'd3);
    chk("t6_pre_grt", 32'(bus_if.grt), 32'd1);
    rst_ = 1'b0;
    #1;
    chk("t6_grt", 32'(bus_if.grt), 32'd0);
    chk("t6_busy", 32'(bus_if.busy), 32'd0);
    chk("t6_xfer", 32'(bus_if.xfer), 32'd0);
    chk("t6_cnt", 32'(bus_if.credit_cnt), 32'd4);
    chk("t6_err", 32'(bus_if.credit_err), 32'd0);
    $display("t6 async reset mid-packet done");

    // ---- 7: owner bubble and non-owner request while busy
    do_reset();
    bus_if.req = 5'b00001;
    tick();
    @(negedge clk);
    chk("t7_f1_xfer", 32'(bus_if.xfer), 32'd1);
    tick();
    bus_if.req = 5'b00010;
    @(negedge clk);
    chk("t7_bub_xfer", 32'(bus_if.xfer), 32'd0);
    chk("t7_bub_grt", 32'(bus_if.grt), 32'd1);
    tick();
    bus_if.req  = 5'b00011;
    bus_if.tail = 5'b11111;
    @(negedge clk);
    chk("t7_f2_xfer", 32'(bus_if.xfer), 32'd1);
    chk("t7_f2_grt", 32'(bus_if.grt), 32'd1);
    tick();
    bus_if.req  = 5'b00010;
    bus_if.tail = '0;
    @(negedge clk);
    chk("t7_idle_grt", 32'(bus_if.grt), 32'd0);
    run_pkt(5'b00010, 1, "t7b");
    $display("t7 bubble and non-owner ignore done");

`ifdef OSCHED_AGING_EN
    // ---- 8: aged unicast input 3 beats a continuously requesting mcast input 1
    do_reset();
    bus_if.req       = 5'b01010;
    bus_if.mcast     = 5'b00010;
    bus_if.tail      = 5'b11111;
    bus_if.credit_in = 1'b1;
    begin
      int n;
      n = 0;
      while (bus_if.grt !== 5'b01000 && n < 40) begin
        tick();
        n++;
      end
      chk("t8_age_cycles", 32'(n), 32'd17);
    end
    bus_if.req       = '0;
    bus_if.credit_in = 1'b0;
    $display("t8 aging grant done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
